// File: rtl/snitch_icache_write_arbiter.sv
// Refill write-port arbiter and flush sequencer in front of the serial icache lookup.
// Build option: define SNITCH_ICACHE_WRITE_ARB_RR_EN for round-robin arbitration (fixed priority otherwise).

package snitch_icache_pkg;
  typedef struct packed {
    int unsigned LINE_COUNT;
    int unsigned COUNT_ALIGN;
    int unsigned SET_ALIGN;
    int unsigned LINE_WIDTH;
    int unsigned TAG_WIDTH;
  } config_t;
endpackage

module snitch_icache_write_arbiter #(
  parameter snitch_icache_pkg::config_t CFG = '0,
  parameter int unsigned NR_REQ = 2,
  localparam int unsigned AW   = (CFG.COUNT_ALIGN > 0) ? CFG.COUNT_ALIGN : 1,
  localparam int unsigned SW   = (CFG.SET_ALIGN   > 0) ? CFG.SET_ALIGN   : 1,
  localparam int unsigned DW   = (CFG.LINE_WIDTH  > 0) ? CFG.LINE_WIDTH  : 1,
  localparam int unsigned TW   = (CFG.TAG_WIDTH   > 0) ? CFG.TAG_WIDTH   : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_valid_i,
  output logic                       flush_ready_o,
  output logic                       flush_valid_o,
  input  logic                       flush_ready_i,
  input  logic [NR_REQ-1:0][AW-1:0]  req_addr_i,
  input  logic [NR_REQ-1:0][SW-1:0]  req_set_i,
  input  logic [NR_REQ-1:0][DW-1:0]  req_data_i,
  input  logic [NR_REQ-1:0][TW-1:0]  req_tag_i,
  input  logic [NR_REQ-1:0]          req_error_i,
  input  logic [NR_REQ-1:0]          req_valid_i,
  output logic [NR_REQ-1:0]          req_ready_o,
  output logic [AW-1:0]              write_addr_o,
  output logic [SW-1:0]              write_set_o,
  output logic [DW-1:0]              write_data_o,
  output logic [TW-1:0]              write_tag_o,
  output logic                       write_error_o,
  output logic                       write_valid_o,
  input  logic                       write_ready_i,
  output logic                       busy_o
);

  localparam int unsigned IdxW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int unsigned CntW = AW + 1;
  localparam logic [CntW-1:0] CntLast =
    CntW'((CFG.LINE_COUNT > 0) ? (CFG.LINE_COUNT - 1) : 0);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT    = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [1:0] BLACKOUT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] pick_idx;
  logic            in_grant;
  logic            sel_valid;
  logic            grant_hs;

  assign in_grant  = (state_q == GRANT);
  assign sel_valid = req_valid_i[idx_q];
  assign grant_hs  = in_grant && sel_valid && write_ready_i;

`ifdef SNITCH_ICACHE_WRITE_ARB_RR_EN
  logic [IdxW-1:0] rr_q;
  logic            pick_found;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NR_REQ) s = s - NR_REQ;
    return IdxW'(s);
  endfunction

  // Search starts at the pointer and wraps, so the last winner goes to the back.
  always_comb begin
    pick_idx   = rr_q;
    pick_found = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (!pick_found && req_valid_i[wrap_idx(rr_q, k)]) begin
        pick_idx   = wrap_idx(rr_q, k);
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
    end else if (grant_hs) begin
      rr_q <= (idx_q == IdxW'(NR_REQ - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end
`else
  always_comb begin
    pick_idx = '0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) pick_idx = IdxW'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_valid_i) begin
          state_d = FLUSH;
        end else if (|req_valid_i) begin
          idx_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_hs) state_d = IDLE;
      end
      FLUSH: begin
        if (flush_ready_i) begin
          cnt_d   = '0;
          state_d = BLACKOUT;
        end
      end
      BLACKOUT: begin
        // Writes stay off while the lookup sweeps its tag array clean.
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = IDLE;
      end
      default: state_d = BLACKOUT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BLACKOUT;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < NR_REQ; gi++) begin : gen_ready
    assign req_ready_o[gi] = in_grant && (idx_q == IdxW'(gi)) && write_ready_i;
  end

  assign write_valid_o = in_grant && sel_valid;
  assign write_addr_o  = in_grant ? req_addr_i[idx_q]  : '0;
  assign write_set_o   = in_grant ? req_set_i[idx_q]   : '0;
  assign write_data_o  = in_grant ? req_data_i[idx_q]  : '0;
  assign write_tag_o   = in_grant ? req_tag_i[idx_q]   : '0;
  assign write_error_o = in_grant ? req_error_i[idx_q] : 1'b0;

  assign flush_valid_o = (state_q == FLUSH);
  assign flush_ready_o = (state_q == FLUSH) && flush_ready_i;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_snitch_icache_write_arbiter.sv
// Bench for snitch_icache_write_arbiter: vector table plus scoreboard, with hand-written
// sequences for reset blackout, flush ordering and asynchronous reset during a grant.
`timescale 1ns/1ps
module tb_snitch_icache_write_arbiter;
  import snitch_icache_pkg::*;

  localparam int LC = 128;
  localparam int NR = 2;
  localparam config_t CFG = '{LINE_COUNT: 128, COUNT_ALIGN: 7, SET_ALIGN: 1,
                              LINE_WIDTH: 32, TAG_WIDTH: 8};

  typedef struct packed {
    logic [6:0]  addr;
    logic [0:0]  set;
    logic [31:0] data;
    logic [7:0]  tag;
    logic        err;
  } pay_t;

  typedef struct {
    logic [1:0] mask;
    int         stall;
    int         exp_hs;
    int         first_fp;
    int         first_rr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_valid_i = 1'b0, flush_ready_o, flush_valid_o, flush_ready_i = 1'b0;
  logic [NR-1:0][6:0]  req_addr = '0;
  logic [NR-1:0][0:0]  req_set = '0;
  logic [NR-1:0][31:0] req_data = '0;
  logic [NR-1:0][7:0]  req_tag = '0;
  logic [NR-1:0]       req_error = '0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready;
  logic [6:0]  write_addr;
  logic [0:0]  write_set;
  logic [31:0] write_data;
  logic [7:0]  write_tag;
  logic        write_error, write_valid;
  logic        write_ready = 1'b0;
  logic        busy;

  snitch_icache_write_arbiter #(.CFG(CFG), .NR_REQ(NR)) dut (
    .clk_i(clk), .rst_i(rst),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .flush_valid_o(flush_valid_o), .flush_ready_i(flush_ready_i),
    .req_addr_i(req_addr), .req_set_i(req_set), .req_data_i(req_data),
    .req_tag_i(req_tag), .req_error_i(req_error),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .write_addr_o(write_addr), .write_set_o(write_set), .write_data_o(write_data),
    .write_tag_o(write_tag), .write_error_o(write_error),
    .write_valid_o(write_valid), .write_ready_i(write_ready),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  pay_t sb0[$], sb1[$];
  int   hs_order[$], hs_cyc[$];
  logic [1:0] drop = '0;
  bit   refill_mode = 0, auto_ready = 0, exp_pending = 0;
  int   stall_cfg = 0, wait_cnt = 0, cyc = 0, exp_idx = 0, rr_model = 0;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [1:0] v, input int rr);
`ifdef SNITCH_ICACHE_WRITE_ARB_RR_EN
    for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) return (rr + k) % NR;
`else
    for (int k = 0; k < NR; k++) if (v[k]) return k;
`endif
    return -1;
  endfunction

  function automatic pay_t cur_payload();
    return {write_addr, write_set, write_data, write_tag, write_error};
  endfunction

  task automatic load_req(input int i);
    pay_t p;
    p.addr = 7'($urandom);
    p.set  = 1'($urandom);
    p.data = $urandom;
    p.tag  = 8'($urandom);
    p.err  = 1'($urandom);
    req_addr[i] = p.addr; req_set[i] = p.set; req_data[i] = p.data;
    req_tag[i] = p.tag;   req_error[i] = p.err;
    req_valid[i] = 1'b1;
    if (i == 0) sb0.push_back(p); else sb1.push_back(p);
  endtask

  task automatic step_begin();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (drop[i]) begin
        if (refill_mode) load_req(i); else req_valid[i] = 1'b0;
      end
    end
    drop = '0;
    if (auto_ready) write_ready = (wait_cnt >= stall_cfg);
  endtask

  task automatic step_end();
    pay_t e, a;
    int g;
    #4;
    cyc++;
    if (write_valid && write_ready) begin
      g = exp_pending ? exp_idx : (req_ready[1] ? 1 : 0);
      chk("hs_expected", 64'(exp_pending), 1);
      chk("grant_onehot", 64'(req_ready), 64'(1) << g);
      a = cur_payload();
      if (g == 0 && sb0.size() > 0) e = sb0.pop_front();
      else if (g == 1 && sb1.size() > 0) e = sb1.pop_front();
      else e = ~a;
      chk("payload", 64'(a), 64'(e));
      $display("TXN cyc=%0d req=%0d addr=%h set=%h data=%h tag=%h err=%b",
               cyc, g, a.addr, a.set, a.data, a.tag, a.err);
      drop[g] = 1'b1;
      hs_order.push_back(g);
      hs_cyc.push_back(cyc);
      rr_model = (g + 1) % NR;
      exp_pending = 0;
      wait_cnt = 0;
    end else if (write_valid) begin
      wait_cnt++;
    end
    if (!busy && !flush_valid_i && req_valid != 0) begin
      exp_idx = model_pick(req_valid, rr_model);
      exp_pending = 1;
    end
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0 || req_valid != 0 || drop != 0) && n < budget) begin
      step_begin();
      step_end();
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d cycles required<%0d", n, budget);
    end
  endtask

  // Releases reset at a falling edge; cycle n is sampled after n rising edges.
  task automatic release_and_blackout(input string tag);
    int bad = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n <= LC; n++) begin
      if (n > 0) step_begin();
      step_end();
      if (n < LC) begin
        if (busy !== 1'b1 || req_ready !== 2'b00 || write_valid !== 1'b0) bad++;
      end else begin
        chk({tag, "_idle_at_LC"}, 64'(busy), 0);
      end
    end
    chk({tag, "_blackout_bad_cycles"}, 64'(bad), 0);
    step_begin();
    step_end();
    chk({tag, "_first_write_valid"}, 64'(write_valid), 1);
  endtask

  task automatic blackout_run(input string tag, input int raise_at);
    int bad = 0;
    for (int n = 0; n < LC; n++) begin
      step_begin();
      if (n == 0) begin flush_valid_i = 1'b0; flush_ready_i = 1'b0; end
      if (n == raise_at) flush_valid_i = 1'b1;
      step_end();
      if (busy !== 1'b1 || req_ready !== 2'b00 || write_valid !== 1'b0 ||
          flush_ready_o !== 1'b0 || flush_valid_o !== 1'b0) bad++;
    end
    chk({tag, "_blackout_bad_cycles"}, 64'(bad), 0);
    step_begin();
    step_end();
    chk({tag, "_idle_after"}, 64'({busy, flush_valid_o}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, bad, exp_first, fi, n;
    pay_t held;

    tbl[0] = '{2'b01, 0, 1, 0, 0};
    tbl[1] = '{2'b10, 1, 1, 1, 1};
    tbl[2] = '{2'b11, 0, 2, 0, 0};
    tbl[3] = '{2'b01, 3, 1, 0, 0};
    tbl[4] = '{2'b11, 2, 2, 0, 1};
    tbl[5] = '{2'b10, 0, 1, 1, 1};
    tbl[6] = '{2'b11, 1, 2, 0, 0};

    // Reset state, then the post-reset blackout with requester 0 waiting.
    @(negedge clk);
    #4;
    chk("reset_outputs", 64'({busy, write_valid, flush_valid_o, flush_ready_o, req_ready}), 64'b100000);
    load_req(0);
    write_ready = 1'b1;
    release_and_blackout("rst");
    run_until_empty(10);

    // Vector table.
    auto_ready = 1;
    for (int v = 0; v < 7; v++) begin
      stall_cfg = tbl[v].stall;
      wait_cnt = 0;
      first = hs_order.size();
      step_begin();
      for (int i = 0; i < NR; i++) if (tbl[v].mask[i]) load_req(i);
      step_end();
      run_until_empty(60);
`ifdef SNITCH_ICACHE_WRITE_ARB_RR_EN
      exp_first = tbl[v].first_rr;
`else
      exp_first = tbl[v].first_fp;
`endif
      fi = (hs_order.size() > first) ? hs_order[first] : -1;
      chk("vec_hs_count", 64'(hs_order.size() - first), 64'(tbl[v].exp_hs));
      chk("vec_first_grant", 64'(fi), 64'(exp_first));
      chk("vec_idle", 64'(busy), 0);
    end

    // Both requesters valid continuously.
    refill_mode = 1; stall_cfg = 0; wait_cnt = 0;
    first = hs_order.size();
    step_begin(); load_req(0); load_req(1); step_end();
    n = 0;
    while (hs_order.size() - first < 8 && n < 40) begin step_begin(); step_end(); n++; end
    chk("cont_budget", 64'(n < 40), 1);
    refill_mode = 0;
    run_until_empty(40);
    bad = 0;
    for (int k = 0; k < 8 && first + k < hs_order.size(); k++) begin
`ifdef SNITCH_ICACHE_WRITE_ARB_RR_EN
      chk("cont_order", 64'(hs_order[first + k]), 64'(k % 2));
`else
      chk("cont_order", 64'(hs_order[first + k]), 0);
`endif
    end
    for (int k = 0; k < 7 && first + k + 1 < hs_cyc.size(); k++)
      if (hs_cyc[first + k + 1] - hs_cyc[first + k] != 2) bad++;
    chk("cont_spacing", 64'(bad), 0);

    // Flush arriving during a stalled grant waits for the write.
    auto_ready = 0; write_ready = 1'b0;
    step_begin(); load_req(0); step_end();
    step_begin(); flush_valid_i = 1'b1; step_end();
    chk("f1_grant_valid", 64'(write_valid), 1);
    held = cur_payload();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step_begin(); step_end(); end
      if (cur_payload() !== held || flush_valid_o !== 1'b0 || write_valid !== 1'b1) bad++;
    end
    chk("f1_stall_stable", 64'(bad), 0);
    step_begin(); write_ready = 1'b1; step_end();
    chk("f1_hs", 64'(req_ready), 64'b01);
    step_begin(); write_ready = 1'b0; step_end();
    chk("f1_idle_before_flush", 64'({busy, flush_valid_o}), 0);
    step_begin(); flush_ready_i = 1'b1; step_end();
    chk("f1_flush", 64'({flush_valid_o, flush_ready_o}), 64'b11);
    blackout_run("f1", 10);
    step_begin(); flush_ready_i = 1'b1; step_end();
    chk("f1_pending_flush", 64'({flush_valid_o, flush_ready_o}), 64'b11);
    blackout_run("f1b", -1);

    // Flush and request 1 in the same IDLE cycle: flush first.
    step_begin(); flush_valid_i = 1'b1; flush_ready_i = 1'b1; load_req(1); step_end();
    chk("f2_idle", 64'({busy, flush_valid_o, flush_ready_o}), 0);
    step_begin(); step_end();
    chk("f2_flush_first", 64'({flush_valid_o, flush_ready_o, req_ready}), 64'b1100);
    blackout_run("f2", -1);
    auto_ready = 1; stall_cfg = 0; wait_cnt = 0;
    first = hs_order.size();
    run_until_empty(10);
    fi = (hs_order.size() > first) ? hs_order[first] : -1;
    chk("f2_grant_req1", 64'(fi), 1);

    // Asynchronous reset in the middle of a grant.
    auto_ready = 0; write_ready = 1'b0;
    step_begin(); load_req(0); step_end();
    step_begin(); step_end();
    chk("r_grant_valid", 64'(write_valid), 1);
    held = cur_payload();
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_drop", 64'({write_valid, busy, req_ready}), 64'b0100);
    sb0.delete();
    sb0.push_back(held);
    exp_pending = 0; rr_model = 0; drop = '0;
    write_ready = 1'b1;
    release_and_blackout("rmid");
    run_until_empty(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
